// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller.
// Walks a 128-bit cipher key through the ten AES-128 expansion rounds,
// borrowing a shared S-box through a request/grant handshake once per
// round, and presents each round key (0..10) with a one-cycle strobe.
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_i,
  output logic         sbox_req_o,
  output logic [31:0]  sbox_word_o,
  input  logic         sbox_gnt_i,
  input  logic [31:0]  sbox_word_i,
  output logic [127:0] rnd_key_o,
  output logic         rnd_key_vld,
  output logic [3:0]   rnd_idx_o,
  output logic         busy,
  output logic         done
);

  // Controller states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SUB_REQ = 2'd1;
  localparam logic [1:0] ST_EXPAND  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [7:0] RCON_FIRST = 8'h01;

  // Doubling in GF(2^8) with the AES reduction polynomial; steps rcon.
  function automatic logic [7:0] rcon_next(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // One AES-128 expansion step; t already holds SubWord(RotWord(w3)) ^ rcon.
  function automatic logic [127:0] expand_key(input logic [127:0] k,
                                              input logic [31:0]  t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q,   key_d;
  logic [3:0]   idx_q,   idx_d;
  logic [7:0]   rcon_q,  rcon_d;
  logic [31:0]  t_q,     t_d;
  logic         vld_q,   vld_d;

  logic [31:0]  rot_w3;
  logic         in_sub_req;

  // RotWord of the last word of the current round key.
  assign rot_w3     = {key_q[23:0], key_q[31:24]};
  assign in_sub_req = (state_q == ST_SUB_REQ);

  // Next-state and datapath decisions for the expansion FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    t_d     = t_q;
    vld_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SUB_REQ;
          key_d   = key_i;
          idx_d   = 4'd0;
          rcon_d  = RCON_FIRST;
          vld_d   = 1'b1;     // round 0 is the cipher key itself
        end
      end

      ST_SUB_REQ: begin
        // Stall here, holding everything, until the shared S-box is granted.
        if (sbox_gnt_i) begin
          t_d     = sbox_word_i ^ {rcon_q, 24'h0};
          state_d = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        key_d  = expand_key(key_q, t_q);
        idx_d  = idx_q + 4'd1;
        rcon_d = rcon_next(rcon_q);
        vld_d  = 1'b1;
        if (idx_q + 4'd1 == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SUB_REQ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; the key register is kept after
  // DONE so the last round key stays visible until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= RCON_FIRST;
      t_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      t_q     <= t_d;
      vld_q   <= vld_d;
    end
  end

  // Outputs: the S-box port is only driven while requesting.
  assign sbox_req_o  = in_sub_req;
  assign sbox_word_o = in_sub_req ? rot_w3 : 32'h0;
  assign rnd_key_o   = key_q;
  assign rnd_key_vld = vld_q;
  assign rnd_idx_o   = idx_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 vector, grant stalls,
// ignored start, mid-run reset, back-to-back starts and random keys/stalls,
// all against a word-level AES-128 key expansion model with its own S-box.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_i;
  logic         sbox_req_o;
  logic [31:0]  sbox_word_o;
  logic         sbox_gnt_i;
  logic [31:0]  sbox_word_i;
  logic [127:0] rnd_key_o;
  logic         rnd_key_vld;
  logic [3:0]   rnd_idx_o;
  logic         busy;
  logic         done;

  int vectors = 0;
  int errors  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [7:0]   RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [127:0] rk [0:10];   // model round keys
  int           tk [0:10];   // cycle at which round k is presented
  int           st [0:9];    // grant-withhold cycles for round k's S-box request
  logic [127:0] hold_key;    // expected rnd_key_o while idle

  aes_key_sched_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_i       (key_i),
    .sbox_req_o  (sbox_req_o),
    .sbox_word_o (sbox_word_o),
    .sbox_gnt_i  (sbox_gnt_i),
    .sbox_word_i (sbox_word_i),
    .rnd_key_o   (rnd_key_o),
    .rnd_key_vld (rnd_key_vld),
    .rnd_idx_o   (rnd_idx_o),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES S-box from first principles ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Combinational S-box serving the DUT.
  assign sbox_word_i = sub_word(sbox_word_o);

  // ---------------- reference model: FIPS-197 word expansion ----------------
  task automatic compute_keys(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word(rot_word(tmp)) ^ {RCON[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= 10; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 128'(busy), 128'(1'b0));
    check({tag, " vld"},  128'(rnd_key_vld), 128'(1'b0));
    check({tag, " done"}, 128'(done), 128'(1'b0));
    check({tag, " req"},  128'(sbox_req_o), 128'(1'b0));
    check({tag, " key"},  rnd_key_o, hold_key);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("idle%0d", i));
      start      = 1'b0;
      sbox_gnt_i = 1'($urandom % 2);
    end
  endtask

  // One expansion. Cycle 0 is the cycle in which start is driven.
  // pulse_c: cycle of an extra (ignored) start with another key, -1 for none.
  // rst_c:   cycle in which rst is asserted to abort, -1 for none.
  task automatic run_exp(input logic [127:0] key, input int pulse_c, input int rst_c,
                         input bit fips, input int fips_done_c);
    int   cur;
    bit   req_e;
    compute_keys(key);
    tk[0] = 1;
    for (int k = 1; k <= 10; k++) tk[k] = tk[k-1] + st[k-1] + 2;

    @(negedge clk);
    check_idle_outputs("pre-start");
    start      = 1'b1;
    key_i      = key;
    sbox_gnt_i = 1'($urandom % 2);

    for (int c = 1; c <= tk[10]; c++) begin
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        check($sformatf("rst req c%0d", c),  128'(sbox_req_o), 128'(1'b0));
        check($sformatf("rst word c%0d", c), 128'(sbox_word_o), 128'(32'h0));
        check($sformatf("rst key c%0d", c),  rnd_key_o, 128'h0);
        check($sformatf("rst vld c%0d", c),  128'(rnd_key_vld), 128'(1'b0));
        check($sformatf("rst idx c%0d", c),  128'(rnd_idx_o), 128'(4'd0));
        check($sformatf("rst busy c%0d", c), 128'(busy), 128'(1'b0));
        check($sformatf("rst done c%0d", c), 128'(done), 128'(1'b0));
        rst      = 1'b0;
        hold_key = '0;
        return;
      end

      cur = 0;
      for (int k = 0; k <= 10; k++) if (c >= tk[k]) cur = k;
      req_e = (cur < 10) && (c <= tk[cur] + st[cur]);

      check($sformatf("vld c%0d", c),  128'(rnd_key_vld), 128'(c == tk[cur]));
      if (c == tk[cur]) check($sformatf("idx c%0d", c), 128'(rnd_idx_o), 128'(cur));
      check($sformatf("key c%0d", c),  rnd_key_o, rk[cur]);
      check($sformatf("busy c%0d", c), 128'(busy), 128'(1'b1));
      check($sformatf("done c%0d", c), 128'(done), 128'(c == tk[10]));
      check($sformatf("req c%0d", c),  128'(sbox_req_o), 128'(req_e));
      if (req_e) check($sformatf("word c%0d", c), 128'(sbox_word_o), 128'(rot_word(rk[cur][31:0])));

      if (fips) begin
        if (c == 1) begin
          check("fips sbox_word c1", 128'(sbox_word_o), 128'(32'hcf4f3c09));
          check("fips sbox_ret c1",  128'(sbox_word_i), 128'(32'h8a84eb01));
        end
        if (c == tk[1]) begin
          check("fips t", 128'(rnd_key_o[127:96] ^ FIPS_KEY[127:96]), 128'(32'h8b84eb01));
          check("fips idx1", rnd_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        if (c == fips_done_c) begin
          check("fips done cycle", 128'(done), 128'(1'b1));
          check("fips idx10", rnd_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end
      end

      // Inputs for the cycle now beginning.
      start = (c == pulse_c);
      if (c == pulse_c) key_i = {$urandom, $urandom, $urandom, $urandom};
      rst = (c == rst_c);
      if (req_e) sbox_gnt_i = (c == tk[cur] + st[cur]);
      else       sbox_gnt_i = 1'($urandom % 2);
    end
    start    = 1'b0;
    hold_key = rk[10];
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < 10; k++) st[k] = 0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;   // start must lose to reset
    key_i      = {$urandom, $urandom, $urandom, $urandom};
    sbox_gnt_i = 1'b1;
    hold_key   = '0;
    clear_stalls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req",  128'(sbox_req_o), 128'(1'b0));
    check("reset word", 128'(sbox_word_o), 128'(32'h0));
    check("reset key",  rnd_key_o, 128'h0);
    check("reset vld",  128'(rnd_key_vld), 128'(1'b0));
    check("reset idx",  128'(rnd_idx_o), 128'(4'd0));
    check("reset busy", 128'(busy), 128'(1'b0));
    check("reset done", 128'(done), 128'(1'b0));
    rst   = 1'b0;
    start = 1'b0;

    // FIPS-197 vector, grant tied high.
    run_exp(FIPS_KEY, -1, -1, 1'b1, 21);
    idle(2);

    // Grant withheld 3 cycles on the round-4 request.
    clear_stalls();
    st[4] = 3;
    run_exp(FIPS_KEY, -1, -1, 1'b1, 24);
    idle(1);

    // Start with another key at cycle 7 must be ignored.
    clear_stalls();
    run_exp(FIPS_KEY, 7, -1, 1'b1, 21);

    // Back-to-back start in the cycle after DONE.
    run_exp(FIPS_KEY, -1, -1, 1'b1, 21);

    // Reset at cycle 9 aborts; no done, then a clean restart.
    run_exp(FIPS_KEY, -1, 9, 1'b1, 21);
    idle(3);
    run_exp(FIPS_KEY, -1, -1, 1'b1, 21);

    // Random keys, random grant stalls, random ignored starts and gaps.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 10; k++) st[k] = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      run_exp({$urandom, $urandom, $urandom, $urandom},
              ($urandom % 2 == 1) ? int'($urandom_range(2, 15)) : -1, -1, 1'b0, 0);
      if ($urandom % 2 == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  begin expansion of key_i; sampled only in IDLE.
REQ-004 SHALL have: key_i  input  128  cipher key; w0 = key_i[127:96] ... w3 = key_i[31:0].
REQ-005 SHALL have: sbox_req_o  output  1  request for the shared S-box.
REQ-006 SHALL have: sbox_word_o  output  32  word to substitute (RotWord of w3).
REQ-007 SHALL have: sbox_gnt_i  input  1  S-box grant; result is valid in the same cycle.
REQ-008 SHALL have: sbox_word_i  input  32  SubWord result (combinational S-box output).
REQ-009 SHALL have: rnd_key_o  output  128  current round key.
REQ-010 SHALL have: rnd_key_vld  output  1  one-cycle strobe; rnd_key_o/rnd_idx_o are valid.
REQ-011 SHALL have: rnd_idx_o  output  4  round index 0..10 of rnd_key_o.
REQ-012 SHALL have: busy  output  1  high from the cycle after start is accepted through DONE.
REQ-013 SHALL have: done  output  1  one-cycle pulse when round 10 is presented.

Function
REQ-014 SHALL implement FSM states IDLE, SUB_REQ, EXPAND, DONE.
REQ-015 SHALL, in IDLE with start=1: load key register <= key_i, rnd_idx <= 0, rcon <= 8'h01, go SUB_REQ.
REQ-016 SHALL assert rnd_key_vld for exactly one cycle on entry to each new round key (idx 0 on the first SUB_REQ cycle, idx k on the cycle after the k-th EXPAND).
REQ-017 SHALL, in SUB_REQ: drive sbox_req_o=1 and sbox_word_o={w3[23:0],w3[31:24]}, both held stable until sbox_gnt_i=1.
REQ-018 SHALL, in a SUB_REQ cycle with sbox_gnt_i=1: capture t <= sbox_word_i ^ {rcon,24'h0} and go EXPAND.
REQ-019 SHALL drive sbox_req_o=0 in every state other than SUB_REQ; sbox_gnt_i outside SUB_REQ is ignored.
REQ-020 SHALL, in EXPAND: compute w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; register the result; rnd_idx +1; rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
REQ-021 SHALL, leaving EXPAND: go DONE if the new rnd_idx = 10, else SUB_REQ.
REQ-022 SHALL, in DONE: assert done=1 together with rnd_key_vld (idx 10), then return to IDLE next cycle.
REQ-023 SHALL keep the rcon sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-024 SHALL, with sbox_gnt_i tied high, present round k at cycle 2k+1 after the start cycle (cycle 0): done at cycle 21, busy at cycles 1..21.
REQ-025 SHALL add one cycle of latency per cycle of grant withholding; no state or output other than the stall changes while waiting.
REQ-026 SHALL ignore start while busy=1; the expansion in progress is unaffected.
REQ-027 SHALL hold rnd_key_o at the last round key after DONE until the next accepted start.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, go to IDLE with: sbox_req_o=0, sbox_word_o=0, rnd_key_o=0, rnd_key_vld=0, rnd_idx_o=0, busy=0, done=0, rcon=8'h01.
REQ-029 SHALL have rst take priority over start and abort any expansion in progress; no done pulse is produced.

Verification
REQ-030 SHALL pass FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with grant tied high -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done at cycle 21.
REQ-031 SHALL show the first S-box request drives sbox_word_o=cf4f3c09; with the bench S-box returning 8a84eb01, the captured t = 8b84eb01.
REQ-032 SHALL show that a grant withheld 3 cycles in round 4 keeps sbox_req_o/sbox_word_o stable, shifts done to cycle 24, and leaves the key values unchanged.
REQ-033 SHALL show that start pulsed at cycle 7 with a different key_i is ignored and the output matches REQ-030.
REQ-034 SHALL show that rst at cycle 9 returns all outputs to reset values next cycle with no done pulse; a following start yields the REQ-030 sequence.
REQ-035 SHALL show that back-to-back start in the cycle after DONE is accepted, with rcon restarting at 01.
